// File: rtl/oh_circ_queue_ctrl.sv
// One-hot head/tail controller for circular queues (ROB/LSQ): pointers, live mask, count, grants.
// Optional simulation checks are compiled in with `define CIRC_QUEUE_CHECK_EN.
module oh_circ_queue_ctrl #(
  parameter int N  = 32,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          alloc_req,
  output logic          alloc_gnt,
  output logic [N-1:0]  alloc_ptr,
  input  logic          free_req,
  output logic          free_gnt,
  input  logic          squash_en,
  input  logic [N-1:0]  squash_oh,
  output logic [N-1:0]  head_oh,
  output logic [N-1:0]  tail_oh,
  output logic [N-1:0]  valid_mask,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int IW = $clog2(N);

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

  function automatic logic [IW-1:0] oh2idx(input logic [N-1:0] v);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) idx = idx | IW'(i);
    return idx;
  endfunction

  logic [N-1:0]  head_q, tail_q, head_n, tail_n;
  logic [CW-1:0] count_q, count_n, sq_dist;
  logic [IW-1:0] head_idx, tail_idx, sq_idx;

  assign head_oh   = head_q;
  assign tail_oh   = tail_q;
  assign alloc_ptr = tail_q;
  assign count     = count_q;
  assign full      = (count_q == CW'(N));
  assign empty     = (count_q == '0);
  assign alloc_gnt = alloc_req & ~full & ~squash_en;
  assign free_gnt  = free_req & ~empty;

  assign head_idx = oh2idx(head_q);
  assign tail_idx = oh2idx(tail_q);
  assign sq_idx   = oh2idx(squash_oh);

  // Wrapped distance from the current head to the squash point (modulo N).
  always_comb begin
    if (sq_idx >= head_idx) sq_dist = CW'(sq_idx) - CW'(head_idx);
    else                    sq_dist = CW'(sq_idx) + CW'(N) - CW'(head_idx);
  end

  always_comb begin
    head_n  = free_gnt ? rotl(head_q) : head_q;
    tail_n  = tail_q;
    count_n = count_q;
    if (squash_en) begin
      // A same-cycle free removes the head from the surviving range.
      tail_n  = rotl(squash_oh);
      count_n = free_gnt ? sq_dist : sq_dist + CW'(1);
    end else begin
      if (alloc_gnt) tail_n = rotl(tail_q);
      if (alloc_gnt && !free_gnt)      count_n = count_q + CW'(1);
      else if (free_gnt && !alloc_gnt) count_n = count_q - CW'(1);
    end
  end

  // head == tail is ambiguous from pointers alone; count resolves full vs empty.
  always_comb begin
    valid_mask = '0;
    if (full) begin
      valid_mask = '1;
    end else if (!empty) begin
      for (int i = 0; i < N; i++) begin
        if (head_idx < tail_idx)
          valid_mask[i] = (i >= int'(head_idx)) && (i < int'(tail_idx));
        else
          valid_mask[i] = (i >= int'(head_idx)) || (i < int'(tail_idx));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= {{(N-1){1'b0}}, 1'b1};
      tail_q  <= {{(N-1){1'b0}}, 1'b1};
      count_q <= '0;
    end else begin
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
    end
  end

`ifdef CIRC_QUEUE_CHECK_EN
  always @(posedge clock) begin
    if (!reset) begin
      if (squash_en && (!$onehot(squash_oh) || ((squash_oh & valid_mask) == '0)))
        $error("oh_circ_queue_ctrl: squash_oh %h not one-hot or not live", squash_oh);
      if (!$onehot(head_q))
        $error("oh_circ_queue_ctrl: head_oh %h not one-hot", head_q);
      if (!$onehot(tail_q))
        $error("oh_circ_queue_ctrl: tail_oh %h not one-hot", tail_q);
      if ($countones(valid_mask) != int'(count_q))
        $error("oh_circ_queue_ctrl: valid_mask %h disagrees with count %0d", valid_mask, count_q);
    end
  end
`endif

endmodule

// File: tb/tb_oh_circ_queue_ctrl.sv
// Directed table-driven bench for oh_circ_queue_ctrl with N=8.
module tb_oh_circ_queue_ctrl;

  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clock = 1'b0;
  logic          reset, alloc_req, free_req, squash_en;
  logic [N-1:0]  squash_oh;
  logic          alloc_gnt, free_gnt, full, empty;
  logic [N-1:0]  alloc_ptr, head_oh, tail_oh, valid_mask;
  logic [CW-1:0] count;

  oh_circ_queue_ctrl #(.N(N)) dut (
    .clock(clock), .reset(reset), .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_ptr(alloc_ptr), .free_req(free_req), .free_gnt(free_gnt),
    .squash_en(squash_en), .squash_oh(squash_oh), .head_oh(head_oh),
    .tail_oh(tail_oh), .valid_mask(valid_mask), .count(count),
    .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       rst, a, f, sq;
    logic [7:0] sqoh;
    logic       chk;
    logic       eag, efg;
    logic [7:0] eh, et;
    logic [3:0] ec;
    logic [7:0] evm;
  } vec_t;

  vec_t       vecs[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] prev_tail = 8'h01;

  function automatic vec_t mkv(input logic rst, a, f, sq, input logic [7:0] sqoh,
                               input logic chk, eag, efg, input logic [7:0] eh, et,
                               input logic [3:0] ec, input logic [7:0] evm);
    vec_t v;
    v = '{rst, a, f, sq, sqoh, chk, eag, efg, eh, et, ec, evm};
    return v;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] mask8(input int h, input int c);
    logic [7:0] m;
    m = '0;
    for (int j = 0; j < c; j++) m[(h + j) % 8] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_row(input vec_t v, input string tag);
    @(negedge clock);
    reset = v.rst; alloc_req = v.a; free_req = v.f; squash_en = v.sq; squash_oh = v.sqoh;
    #1;
    if (v.chk) begin
      chk({tag, " alloc_gnt"}, 32'(alloc_gnt), 32'(v.eag));
      chk({tag, " free_gnt"}, 32'(free_gnt), 32'(v.efg));
      chk({tag, " alloc_ptr"}, 32'(alloc_ptr), 32'(prev_tail));
    end
    @(posedge clock);
    #1;
    chk({tag, " head_oh"}, 32'(head_oh), 32'(v.eh));
    chk({tag, " tail_oh"}, 32'(tail_oh), 32'(v.et));
    chk({tag, " count"}, 32'(count), 32'(v.ec));
    chk({tag, " valid_mask"}, 32'(valid_mask), 32'(v.evm));
    chk({tag, " full"}, 32'(full), 32'(v.ec == 4'd8));
    chk({tag, " empty"}, 32'(empty), 32'(v.ec == 4'd0));
    prev_tail = v.et;
  endtask

  initial begin
    logic [7:0] t;
    reset = 1'b1; alloc_req = 1'b0; free_req = 1'b0; squash_en = 1'b0; squash_oh = '0;

    //           rst a f sq sqoh  chk ag fg head   tail   cnt  vmask
    vecs.push_back(mkv(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h01, 0, 8'h00));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h02, 1, 8'h01));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h04, 2, 8'h03));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h08, 3, 8'h07));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h10, 4, 8'h0F));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h20, 5, 8'h1F));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h40, 6, 8'h3F));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h80, 7, 8'h7F));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h01, 8, 8'hFF));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h01, 8'h01, 8, 8'hFF));
    vecs.push_back(mkv(0, 1, 1, 0, 8'h00, 1, 0, 1, 8'h02, 8'h01, 7, 8'hFE));
    vecs.push_back(mkv(1, 1, 0, 0, 8'h00, 0, 0, 0, 8'h01, 8'h01, 0, 8'h00));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h02, 1, 8'h01));
    vecs.push_back(mkv(0, 1, 1, 0, 8'h00, 1, 1, 1, 8'h02, 8'h04, 1, 8'h02));
    vecs.push_back(mkv(0, 1, 1, 0, 8'h00, 1, 1, 1, 8'h04, 8'h08, 1, 8'h04));
    vecs.push_back(mkv(0, 1, 1, 0, 8'h00, 1, 1, 1, 8'h08, 8'h10, 1, 8'h08));
    vecs.push_back(mkv(0, 1, 1, 0, 8'h00, 1, 1, 1, 8'h10, 8'h20, 1, 8'h10));
    vecs.push_back(mkv(0, 1, 1, 0, 8'h00, 1, 1, 1, 8'h20, 8'h40, 1, 8'h20));
    vecs.push_back(mkv(0, 0, 1, 0, 8'h00, 1, 0, 1, 8'h40, 8'h40, 0, 8'h00));
    vecs.push_back(mkv(0, 1, 1, 0, 8'h00, 1, 1, 0, 8'h40, 8'h80, 1, 8'h40));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h40, 8'h01, 2, 8'hC0));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h40, 8'h02, 3, 8'hC1));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h40, 8'h04, 4, 8'hC3));
    vecs.push_back(mkv(0, 0, 1, 0, 8'h00, 1, 0, 1, 8'h80, 8'h04, 3, 8'h83));
    vecs.push_back(mkv(0, 0, 1, 0, 8'h00, 1, 0, 1, 8'h01, 8'h04, 2, 8'h03));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h08, 3, 8'h07));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h10, 4, 8'h0F));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h01, 8'h20, 5, 8'h1F));
    vecs.push_back(mkv(0, 1, 0, 1, 8'h04, 1, 0, 0, 8'h01, 8'h08, 3, 8'h07));
    vecs.push_back(mkv(0, 0, 1, 0, 8'h00, 1, 0, 1, 8'h02, 8'h08, 2, 8'h06));
    vecs.push_back(mkv(0, 0, 1, 0, 8'h00, 1, 0, 1, 8'h04, 8'h08, 1, 8'h04));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h04, 8'h10, 2, 8'h0C));
    vecs.push_back(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h04, 8'h20, 3, 8'h1C));
    vecs.push_back(mkv(0, 0, 1, 1, 8'h04, 1, 0, 1, 8'h08, 8'h08, 0, 8'h00));

    for (int i = 0; i < vecs.size(); i++)
      run_row(vecs[i], $sformatf("row%0d", i));

    // Fill from head=08 until full, then squash at the youngest entry while full.
    t = 8'h08;
    for (int k = 0; k < 8; k++) begin
      t = rotl8(t);
      run_row(mkv(0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h08, t, 4'(k + 1), mask8(3, k + 1)),
              $sformatf("fill%0d", k));
    end
    run_row(mkv(0, 1, 0, 1, 8'h04, 1, 0, 0, 8'h08, 8'h08, 8, 8'hFF), "sq_full");
    run_row(mkv(0, 0, 0, 1, 8'h08, 1, 0, 0, 8'h08, 8'h10, 1, 8'h08), "sq_head");
    run_row(mkv(0, 0, 1, 1, 8'h08, 1, 0, 1, 8'h10, 8'h10, 0, 8'h00), "sq_head_free");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oh_circ_queue_ctrl.md
Name: oh_circ_queue_ctrl

Overview:
Head/tail controller for circular buffers (ROB, LSQ) that keeps both pointers as one-hot vectors. It sits directly upstream of the one-hot-to-thermometer converters: head_oh, tail_oh and squash_oh feed those converters to build age and squash masks. The block also produces the live-entry mask, occupancy count, full/empty flags, and allocate/retire/squash handshakes.

Parameters:
N, 32, number of queue entries (>=2); also the width of all one-hot vectors.
CW, $clog2(N+1), width of the count output.

Ports:
clock  in  1  system clock, all state updates on posedge.
reset  in  1  synchronous, active-high; sampled on posedge clock.
alloc_req  in  1  request to allocate the entry at the tail.
alloc_gnt  out  1  allocation accepted this cycle (combinational).
alloc_ptr  out  N  one-hot index of the granted entry; equals tail_oh.
free_req  in  1  request to retire the entry at the head.
free_gnt  out  1  retire accepted this cycle (combinational).
squash_en  in  1  squash every entry younger than squash_oh.
squash_oh  in  N  one-hot index of the youngest surviving entry.
head_oh  out  N  one-hot oldest-entry pointer.
tail_oh  out  N  one-hot next-free-entry pointer.
valid_mask  out  N  bit i = 1 iff entry i is live.
count  out  CW  number of live entries, 0..N.
full  out  1  count == N.
empty  out  1  count == 0.

Behaviour:
- Reset values: head_oh = tail_oh = 1 (entry 0), count = 0, empty = 1, full = 0, valid_mask = 0, alloc_gnt = free_gnt = 0.
- Registered state: head_oh, tail_oh, count. full, empty, valid_mask and the grants are combinational from state and inputs.
- Pointer advance: rotate left by 1. Bit N-1 wraps to bit 0.
- alloc_gnt = alloc_req & ~full & ~squash_en.
  - On grant, next tail_oh = rotl(tail_oh) and count increments.
  - A full queue blocks allocation even when a free is granted the same cycle (no full-bypass).
- free_gnt = free_req & ~empty.
  - On grant, next head_oh = rotl(head_oh) and count decrements.
  - An empty queue blocks free even when an alloc is granted the same cycle.
- Alloc and free in the same cycle: both pointers advance and count is unchanged.
- Squash:
  - Squash has priority over alloc; alloc is suppressed that cycle.
  - Next tail_oh = rotl(squash_oh).
  - Next count = number of entries from head (after any same-cycle free) through squash_oh inclusive, wrapping.
  - Squash combined with a free of that same head entry (squash_oh == head_oh): next state is empty, with head_oh = tail_oh = rotl(old head_oh).
  - squash_oh must be one-hot and live; any other value is illegal and the resulting state is unspecified.
- valid_mask:
  - empty: all zeros.
  - full: all ones.
  - Otherwise, the bits from head index up to tail index - 1, wrapping past N-1.
  - popcount(valid_mask) == count always.
- Latency: grants are same cycle; pointer, count and flag changes are visible the cycle after the grant.
- Reset mid-operation: reset overrides all requests in that cycle; the next cycle shows the reset values.

Optional Feature:
- Macro CIRC_QUEUE_CHECK_EN.
- When defined, simulation-only checks fire $error on any of:
  - squash_en with squash_oh not one-hot, or pointing at a non-live entry;
  - head_oh or tail_oh not one-hot;
  - popcount(valid_mask) != count.
- Checks are disabled while reset is high.
- When undefined, no checking logic exists; functional behaviour is identical.

Test Plan:
- N=8, reset, then 8 consecutive alloc_req -> alloc_ptr steps 01,02,..,80; after the 8th grant: full=1, count=8, valid_mask=FF, tail_oh=01. A 9th alloc_req -> alloc_gnt=0.
- From full, alloc_req+free_req together -> free_gnt=1, alloc_gnt=0; next cycle head_oh=02, count=7, valid_mask=FE.
- Wrap-around: N=8, head_oh=40, 4 allocs -> tail_oh=04, valid_mask=C3, count=4; free_req twice -> head_oh=01, count=2, valid_mask=03.
- Squash: head_oh=01, tail_oh=20 (count 5); squash_en, squash_oh=04, with alloc_req also high -> alloc_gnt=0; next tail_oh=08, count=3, valid_mask=07.
- Squash on head with free: head_oh=04, count=3; squash_oh=04 plus free_req -> next empty=1, head_oh=tail_oh=08, valid_mask=00.
- Reset asserted mid-stream with alloc_req=1 -> next cycle head_oh=tail_oh=01, count=0, empty=1, no pointer advance from that cycle's request.
